// File: rtl/pipe_control.sv
// pipe_control: button/switch front end, frame-aligned filter commit with flush, threshold stepper
// Ports:
//   i_sysclk, i_rst      - single clock, synchronous active-high reset
//   i_sof                - start-of-frame pulse
//   i_btn_mode/inc/dec   - raw buttons (synchronised + debounced, rising edge = event)
//   i_sw_filter          - raw filter switches (synchronised only)
//   o_cfg_start          - one-cycle pulse after reset release
//   o_mode               - 0 passthrough, 1 processing
//   o_filter_enable      - committed enables, updated only on a frame start
//   o_pipe_flush         - high for FLUSH_CYCLES after each commit
//   o_threshold, o_at_min, o_at_max - saturating threshold and bound flags
// Optional: PIPE_CONTROL_AUTOREPEAT_EN adds auto-repeat on held inc/dec buttons.
module pipe_control #(
    parameter int unsigned NUM_FILTERS   = 2,
    parameter int unsigned THRESH_W      = 26,
    parameter int unsigned THRESH_INIT   = 4000,
    parameter int unsigned THRESH_STEP   = 500,
    parameter int unsigned THRESH_MIN    = 0,
    parameter int unsigned THRESH_MAX    = 50000,
    parameter int unsigned DB_COUNT      = 500000,
    parameter int unsigned FLUSH_CYCLES  = 16,
    parameter int unsigned REPEAT_CYCLES = 12500000
) (
    input  logic                   i_sysclk,
    input  logic                   i_rst,
    input  logic                   i_sof,
    input  logic                   i_btn_mode,
    input  logic                   i_btn_inc,
    input  logic                   i_btn_dec,
    input  logic [NUM_FILTERS-1:0] i_sw_filter,
    output logic                   o_cfg_start,
    output logic                   o_mode,
    output logic [NUM_FILTERS-1:0] o_filter_enable,
    output logic                   o_pipe_flush,
    output logic [THRESH_W-1:0]    o_threshold,
    output logic                   o_at_min,
    output logic                   o_at_max
);
    localparam int DB_W = $clog2(DB_COUNT + 1);
    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
    localparam int TW1  = THRESH_W + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [THRESH_W:0]   STEP_X = TW1'(THRESH_STEP);
    localparam logic [THRESH_W:0]   MIN_X  = TW1'(THRESH_MIN);
    localparam logic [THRESH_W:0]   MAX_X  = TW1'(THRESH_MAX);
    localparam logic [THRESH_W-1:0] TH_MIN = THRESH_W'(THRESH_MIN);
    localparam logic [THRESH_W-1:0] TH_MAX = THRESH_W'(THRESH_MAX);
    localparam logic [THRESH_W-1:0] TH_INI = THRESH_W'(THRESH_INIT);

    // bit 0 = mode, bit 1 = inc, bit 2 = dec
    logic [2:0] btn_raw;
    logic [2:0] meta_q, sync_q, db_q, db_d, db_prev_q, btn_rise, ev;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];
    logic [NUM_FILTERS-1:0] sw_meta_q, sw_sync_q, target;
    logic cfg_done_q, cfg_start_q, cfg_start_d;
    logic mode_q, mode_d;
    logic [1:0] state_q, state_d;
    logic [NUM_FILTERS-1:0] fe_q, fe_d;
    logic [FL_W-1:0] fcnt_q, fcnt_d;
    logic [THRESH_W:0] th_sum;
    logic [THRESH_W-1:0] th_q, th_d, th_up, th_dn;
    logic at_min_q, at_min_d, at_max_q, at_max_d;

    assign btn_raw = {i_btn_dec, i_btn_inc, i_btn_mode};

    // a level is accepted once the synchronised input has differed from it for DB_COUNT cycles
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            db_cnt_d[b] = '0;
            db_d[b]     = db_q[b];
            if (sync_q[b] != db_q[b]) begin
                if (db_cnt_q[b] == DB_W'(DB_COUNT - 1)) db_d[b] = sync_q[b];
                else db_cnt_d[b] = db_cnt_q[b] + 1'b1;
            end
        end
    end

    assign btn_rise = db_q & ~db_prev_q;

`ifdef PIPE_CONTROL_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    logic [RP_W-1:0] rep_cnt_q [2];
    logic [RP_W-1:0] rep_cnt_d [2];
    logic [1:0] rep;

    // counter restarts on the initial edge so repeats land REPEAT_CYCLES apart from it
    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rep[r]       = db_q[r+1] & db_prev_q[r+1] & (rep_cnt_q[r] == RP_W'(REPEAT_CYCLES - 1));
            rep_cnt_d[r] = (!db_q[r+1] || btn_rise[r+1] || rep[r]) ? '0 : rep_cnt_q[r] + 1'b1;
        end
    end

    always_ff @(posedge i_sysclk) begin
        for (int r = 0; r < 2; r++) rep_cnt_q[r] <= i_rst ? '0 : rep_cnt_d[r];
    end

    assign ev = btn_rise | {rep, 1'b0};
`else
    assign ev = btn_rise;
`endif

    assign target = mode_q ? sw_sync_q : '0;

    always_comb begin
        cfg_start_d = ~cfg_done_q;
        mode_d      = mode_q ^ ev[0];
        state_d     = state_q;
        fe_d        = fe_q;
        fcnt_d      = fcnt_q;
        case (state_q)
            S_IDLE:  if (target != fe_q) state_d = S_PEND;
            S_PEND:  if (i_sof) begin
                         fe_d    = target;
                         fcnt_d  = FL_W'(FLUSH_CYCLES - 1);
                         state_d = S_FLUSH;
                     end
            S_FLUSH: if (fcnt_q == '0) state_d = S_IDLE;
                     else fcnt_d = fcnt_q - 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    // widened by one bit so the increment saturates instead of wrapping
    always_comb begin
        th_sum   = {1'b0, th_q} + STEP_X;
        th_up    = (th_sum > MAX_X) ? TH_MAX : th_sum[THRESH_W-1:0];
        th_dn    = ({1'b0, th_q} < MIN_X + STEP_X) ? TH_MIN : th_q - STEP_X[THRESH_W-1:0];
        th_d     = (ev[1] & ~ev[2]) ? th_up : (ev[2] & ~ev[1]) ? th_dn : th_q;
        at_min_d = th_d == TH_MIN;
        at_max_d = th_d == TH_MAX;
    end

    always_ff @(posedge i_sysclk) begin
        if (i_rst) begin
            meta_q      <= '0;
            sync_q      <= '0;
            db_q        <= '0;
            db_prev_q   <= '0;
            for (int b = 0; b < 3; b++) db_cnt_q[b] <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            cfg_done_q  <= 1'b0;
            cfg_start_q <= 1'b0;
            mode_q      <= 1'b0;
            state_q     <= S_IDLE;
            fe_q        <= '0;
            fcnt_q      <= '0;
            th_q        <= TH_INI;
            at_min_q    <= TH_INI == TH_MIN;
            at_max_q    <= TH_INI == TH_MAX;
        end else begin
            meta_q      <= btn_raw;
            sync_q      <= meta_q;
            db_q        <= db_d;
            db_prev_q   <= db_q;
            for (int b = 0; b < 3; b++) db_cnt_q[b] <= db_cnt_d[b];
            sw_meta_q   <= i_sw_filter;
            sw_sync_q   <= sw_meta_q;
            cfg_done_q  <= 1'b1;
            cfg_start_q <= cfg_start_d;
            mode_q      <= mode_d;
            state_q     <= state_d;
            fe_q        <= fe_d;
            fcnt_q      <= fcnt_d;
            th_q        <= th_d;
            at_min_q    <= at_min_d;
            at_max_q    <= at_max_d;
        end
    end

    assign o_cfg_start     = cfg_start_q;
    assign o_mode          = mode_q;
    assign o_filter_enable = fe_q;
    assign o_pipe_flush    = state_q == S_FLUSH;
    assign o_threshold     = th_q;
    assign o_at_min        = at_min_q;
    assign o_at_max        = at_max_q;
endmodule
